// File: rtl/jtpopeye_objline.sv
// -----------------------------------------------------------------------------
// jtpopeye_objline
// Double-buffered object line store. One bank is filled with object entries
// during a line while the other bank, filled during the previous line, is
// read out in order. A line_start strobe swaps the banks.
//
// Parameters
//   AW : address width, each bank holds 2^AW entries
//   DW : entry data width
//
// Ports
//   clk        : clock
//   rst_n      : asynchronous active-low reset (storage is not cleared)
//   cen        : clock enable, gates every state update
//   line_start : swap banks / start a new line (sampled with cen)
//   wr_en      : write wr_data into the write bank
//   wr_data    : entry to store
//   wr_full    : write bank holds 2^AW entries
//   rd_en      : fetch the next entry of the read bank
//   rd_data    : entry read (held between reads)
//   rd_valid   : rd_data carries a new entry for this cen cycle
//   rd_last    : rd_data is the final entry of the line
//   rd_count   : number of entries in the current read bank
//   ovf        : sticky flag, a write was dropped during this line
//   bank       : current write bank (read bank is ~bank)
//
// Configuration
//   JTPOPEYE_OBJLINE_CLR_EN : when defined, each entry read is zeroed in the
//   read bank on the cen cycle after it is presented.
// -----------------------------------------------------------------------------
module jtpopeye_objline #(
   parameter int AW = 6,
   parameter int DW = 18
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cen,
   input  logic          line_start,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   output logic          wr_full,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   output logic          rd_last,
   output logic [AW:0]   rd_count,
   output logic          ovf,
   output logic          bank
);

   localparam int          DEPTH = 1 << AW;
   localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

   // Both banks share one array; the bank bit is the address MSB.
   logic [DW-1:0] mem_q [0:2*DEPTH-1];

   logic          bank_q,     bank_d;
   logic [AW:0]   wptr_q,     wptr_d;
   logic [AW:0]   rptr_q,     rptr_d;
   logic [AW:0]   rd_count_q, rd_count_d;
   logic          ovf_q,      ovf_d;
   logic          rd_valid_q, rd_valid_d;
   logic          rd_last_q,  rd_last_d;
   logic [DW-1:0] rd_data_q;

   logic          wr_do;
   logic [AW:0]   wr_addr;
   logic          rd_do;
   logic [AW:0]   rd_addr;

   always_comb begin
      bank_d     = bank_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      rd_count_d = rd_count_q;
      ovf_d      = ovf_q;
      rd_valid_d = rd_valid_q;
      rd_last_d  = rd_last_q;
      wr_do      = 1'b0;
      wr_addr    = {bank_q, wptr_q[AW-1:0]};
      rd_do      = 1'b0;
      rd_addr    = {~bank_q, rptr_q[AW-1:0]};
      // rst_n is included so that the unreset storage array is never
      // written while the control state is held in reset.
      if (cen && rst_n) begin
         rd_valid_d = 1'b0;
         rd_last_d  = 1'b0;
         if (line_start) begin
            bank_d     = ~bank_q;
            rd_count_d = wptr_q;
            rptr_d     = '0;
            ovf_d      = 1'b0;
            // A coincident write belongs to the new line: entry 0 of the
            // bank that becomes the write bank on this edge.
            if (wr_en) begin
               wr_do   = 1'b1;
               wr_addr = {~bank_q, {AW{1'b0}}};
               wptr_d  = ONE;
            end else begin
               wptr_d  = '0;
            end
         end else begin
            if (wr_en) begin
               if (!wptr_q[AW]) begin
                  wr_do  = 1'b1;
                  wptr_d = wptr_q + ONE;
               end else begin
                  ovf_d  = 1'b1;
               end
            end
            // rptr stops at rd_count; extra requests only drop rd_valid.
            if (rd_en && (rptr_q < rd_count_q)) begin
               rd_do      = 1'b1;
               rd_valid_d = 1'b1;
               rd_last_d  = (rptr_q == (rd_count_q - ONE));
               rptr_d     = rptr_q + ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_q     <= 1'b0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         rd_count_q <= '0;
         ovf_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
      end else begin
         bank_q     <= bank_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         rd_count_q <= rd_count_d;
         ovf_q      <= ovf_d;
         rd_valid_q <= rd_valid_d;
         rd_last_q  <= rd_last_d;
      end
   end

   // Registered read port; the value is held until the next accepted read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else if (rd_do) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

`ifdef JTPOPEYE_OBJLINE_CLR_EN
   // The entry just presented is cleared on the following cen cycle.
   logic        clr_pend_q;
   logic [AW:0] clr_addr_q;
   logic        clr_do;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_pend_q <= 1'b0;
         clr_addr_q <= '0;
      end else if (cen) begin
         clr_pend_q <= rd_do;
         if (rd_do) begin
            clr_addr_q <= rd_addr;
         end
      end
   end

   assign clr_do = cen && rst_n && clr_pend_q;

   // Clear first, write second: if a new-line write hits the entry being
   // cleared (entry 0 right after a swap), the fresh data must survive.
   always_ff @(posedge clk) begin
      if (clr_do) begin
         mem_q[clr_addr_q] <= '0;
      end
      if (wr_do) begin
         mem_q[wr_addr] <= wr_data;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (wr_do) begin
         mem_q[wr_addr] <= wr_data;
      end
   end
`endif

   assign wr_full  = wptr_q[AW];
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign rd_last  = rd_last_q;
   assign rd_count = rd_count_q;
   assign ovf      = ovf_q;
   assign bank     = bank_q;

endmodule

// File: tb/tb_jtpopeye_objline.sv
module tb_jtpopeye_objline;

   localparam int AW    = 6;
   localparam int DW    = 18;
   localparam int DEPTH = 64;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cen = 1'b0;
   logic          line_start = 1'b0;
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_full;
   logic          rd_en = 1'b0;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          rd_last;
   logic [AW:0]   rd_count;
   logic          ovf;
   logic          bank;

   always #5 clk = ~clk;

   jtpopeye_objline #(.AW(AW), .DW(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cen        (cen),
      .line_start (line_start),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .wr_full    (wr_full),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_last    (rd_last),
      .rd_count   (rd_count),
      .ovf        (ovf),
      .bank       (bank)
   );

   // Behavioural reference: two arrays of line contents plus counters.
   logic [DW-1:0] m_mem [0:1][0:DEPTH-1];
   int            m_bank, m_wcnt, m_rpos, m_cnt;
   logic          m_ovf, m_valid, m_last;
   logic [DW-1:0] m_data;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_bank = 0; m_wcnt = 0; m_rpos = 0; m_cnt = 0;
      m_ovf = 1'b0; m_valid = 1'b0; m_last = 1'b0; m_data = '0;
   endtask

   task automatic model_edge();
      if (!cen) return;
      if (line_start) begin
         m_bank  = 1 - m_bank;
         m_cnt   = m_wcnt;
         m_rpos  = 0;
         m_ovf   = 1'b0;
         m_valid = 1'b0;
         m_last  = 1'b0;
         if (wr_en) begin
            m_mem[m_bank][0] = wr_data;
            m_wcnt = 1;
         end else begin
            m_wcnt = 0;
         end
      end else begin
         if (wr_en) begin
            if (m_wcnt < DEPTH) begin
               m_mem[m_bank][m_wcnt] = wr_data;
               m_wcnt++;
            end else begin
               m_ovf = 1'b1;
            end
         end
         if (rd_en && m_rpos < m_cnt) begin
            m_data  = m_mem[1-m_bank][m_rpos];
`ifdef JTPOPEYE_OBJLINE_CLR_EN
            m_mem[1-m_bank][m_rpos] = '0;
`endif
            m_valid = 1'b1;
            m_last  = (m_rpos == m_cnt - 1);
            m_rpos++;
         end else begin
            m_valid = 1'b0;
            m_last  = 1'b0;
         end
      end
   endtask

   task automatic compare_all();
      chk("bank",     32'(bank),     32'(m_bank));
      chk("rd_count", 32'(rd_count), 32'(m_cnt));
      chk("ovf",      32'(ovf),      32'(m_ovf));
      chk("wr_full",  32'(wr_full),  32'(m_wcnt == DEPTH));
      chk("rd_valid", 32'(rd_valid), 32'(m_valid));
      chk("rd_last",  32'(rd_last),  32'(m_last));
      chk("rd_data",  32'(rd_data),  32'(m_data));
   endtask

   // One cen-qualified clock: drive, let the edge happen, model it, compare.
   task automatic step(input bit ls, input bit we, input logic [DW-1:0] wd,
                       input bit re, input bit c);
      cen = c; line_start = ls; wr_en = we; wr_data = wd; rd_en = re;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] exp3 [0:2];
      logic [DW-1:0] orig [0:3];
      logic          s_valid, s_last, s_ovf, s_full, s_bank;
      logic [DW-1:0] s_data;
      logic [AW:0]   s_cnt;
      int            bsel, line_len, line_pos;

      // Reset state
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      compare_all();
      chk("rst_data", 32'(rd_data), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Five entries in bank 0, read back in order after the swap
      for (int i = 1; i <= 5; i++) step(0, 1, DW'(i), 0, 1);
      step(1, 0, '0, 0, 1);
      chk("swap_bank", 32'(bank), 32'd1);
      chk("swap_cnt",  32'(rd_count), 32'd5);
      for (int i = 1; i <= 5; i++) begin
         step(0, 0, '0, 1, 1);
         chk("seq_data",  32'(rd_data),  32'(i));
         chk("seq_valid", 32'(rd_valid), 32'd1);
         chk("seq_last",  32'(rd_last),  32'(i == 5));
      end
      step(0, 0, '0, 1, 1);
      chk("end_valid", 32'(rd_valid), 32'd0);
      chk("end_hold",  32'(rd_data),  32'd5);

      // 65 writes in one line: full after 64, overflow on the 65th
      for (int i = 0; i < 65; i++) begin
         step(0, 1, DW'(18'h100 + i), 0, 1);
         if (i == 62) chk("full_early", 32'(wr_full), 32'd0);
         if (i == 63) begin
            chk("full_64", 32'(wr_full), 32'd1);
            chk("ovf_64",  32'(ovf),     32'd0);
         end
         if (i == 64) chk("ovf_65", 32'(ovf), 32'd1);
      end

      // Swap with a coincident write landing at entry 0 of the new bank
      step(1, 1, 18'h3FFFF, 0, 1);
      chk("cnt_64",   32'(rd_count), 32'd64);
      chk("ovf_clr",  32'(ovf),      32'd0);
      chk("full_clr", 32'(wr_full),  32'd0);
      for (int i = 0; i < 64; i++) begin
         step(0, 0, '0, 1, 1);
         chk("rd64_data", 32'(rd_data), 32'(18'h100 + i));
         if (i == 63) chk("rd64_last", 32'(rd_last), 32'd1);
      end
      step(0, 1, 18'h0AAAA, 0, 1);
      step(0, 1, 18'h05555, 0, 1);
      step(1, 0, '0, 0, 1);
      chk("cnt_3", 32'(rd_count), 32'd3);

      // Five reads of a three-entry line
      exp3[0] = 18'h3FFFF; exp3[1] = 18'h0AAAA; exp3[2] = 18'h05555;
      for (int i = 0; i < 5; i++) begin
         step(0, 0, '0, 1, 1);
         if (i < 3) begin
            chk("r3_valid", 32'(rd_valid), 32'd1);
            chk("r3_data",  32'(rd_data),  32'(exp3[i]));
         end else begin
            chk("r3_idle",  32'(rd_valid), 32'd0);
            chk("r3_hold",  32'(rd_data),  32'(exp3[2]));
         end
      end

      // cen low for 10 cycles with activity on every request input
      step(0, 1, 18'h00777, 1, 1);
      s_valid = rd_valid; s_last = rd_last; s_ovf = ovf; s_full = wr_full;
      s_bank = bank; s_data = rd_data; s_cnt = rd_count;
      for (int i = 0; i < 10; i++) begin
         step(i[0], 1, DW'($urandom), 1, 0);
         chk("hold_valid", 32'(rd_valid), 32'(s_valid));
         chk("hold_data",  32'(rd_data),  32'(s_data));
         chk("hold_bank",  32'(bank),     32'(s_bank));
         chk("hold_cnt",   32'(rd_count), 32'(s_cnt));
         chk("hold_misc",  {29'd0, s_last, s_ovf, s_full} ^ {29'd0, rd_last, ovf, wr_full}, 32'd0);
      end

      // Read request coinciding with a swap is discarded
      step(1, 0, '0, 1, 1);
      chk("ls_rd_drop", 32'(rd_valid), 32'd0);
      chk("ls_cnt",     32'(rd_count), 32'd1);

      // Clear-on-read check through the storage array
      step(1, 0, '0, 0, 1);
      bsel = m_bank;
      for (int i = 0; i < 4; i++) begin
         orig[i] = DW'(18'h12340 + i * 3);
         step(0, 1, orig[i], 0, 1);
      end
      step(1, 0, '0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, '0, 1, 1);
         chk("clr_rd", 32'(rd_data), 32'(orig[i]));
      end
      step(1, 0, '0, 0, 1);
      step(1, 0, '0, 0, 1);
      chk("clr_cnt", 32'(rd_count), 32'd0);
      step(0, 0, '0, 1, 1);
      chk("clr_novalid", 32'(rd_valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
`ifdef JTPOPEYE_OBJLINE_CLR_EN
         chk("backdoor", 32'(dut.mem_q[bsel*DEPTH + i]), 32'd0);
`else
         chk("backdoor", 32'(dut.mem_q[bsel*DEPTH + i]), 32'(orig[i]));
`endif
      end

      // Reset in the middle of a line: immediate, storage untouched
      step(0, 1, 18'h00ABC, 0, 1);
      step(0, 1, 18'h00DEF, 0, 1);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      cen = 1'b1; wr_en = 1'b1; rd_en = 1'b1; line_start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, '0, 1, 1);
      chk("post_rst_rd", 32'(rd_valid), 32'd0);

      // Randomised traffic with lines of varying length
      line_len = $urandom_range(5, 150);
      line_pos = 0;
      for (int n = 0; n < 4000; n++) begin
         bit ls, we, re, c;
         c  = ($urandom_range(0, 99) < 80);
         we = ($urandom_range(0, 99) < 60);
         re = ($urandom_range(0, 99) < 60);
         ls = 1'b0;
         if (c) line_pos++;
         if (c && line_pos >= line_len) begin
            ls = 1'b1;
            line_pos = 0;
            line_len = $urandom_range(5, 150);
         end
         step(ls, we, DW'($urandom), re, c);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/jtpopeye_objline.md
JTPOPEYE_OBJLINE -- requirements
Module: jtpopeye_objline

Interface
REQ-001 Parameter AW, default 6, SHALL set the address width: each line bank holds 2^AW entries.
REQ-002 Parameter DW, default 18, SHALL set the entry data width.
REQ-003 Port clk, input, 1, SHALL be the single clock for all logic.
REQ-004 Port rst_n, input, 1, SHALL be the asynchronous active-low reset.
REQ-005 Port cen, input, 1, SHALL gate every state update except reset.
REQ-006 Port line_start, input, 1, SHALL be the new-line strobe that swaps banks, sampled when cen=1.
REQ-007 Port wr_en, input, 1, SHALL request a write of wr_data into the write bank.
REQ-008 Port wr_data, input, DW, SHALL carry the entry to store.
REQ-009 Port wr_full, output, 1, SHALL be high when the write bank holds 2^AW entries.
REQ-010 Port rd_en, input, 1, SHALL request the next entry from the read bank.
REQ-011 Port rd_data, output, DW, SHALL carry the entry read.
REQ-012 Port rd_valid, output, 1, SHALL qualify rd_data for one cen cycle.
REQ-013 Port rd_last, output, 1, SHALL mark the final valid entry of the line.
REQ-014 Port rd_count, output, AW+1, SHALL give the entry count of the current read bank.
REQ-015 Port ovf, output, 1, SHALL be the sticky per-line overflow flag.
REQ-016 Port bank, output, 1, SHALL show which bank (0/1) is the current write bank.

Function
REQ-017 Two banks of 2^AW x DW SHALL exist; the write bank is selected by bank and the read bank is ~bank.
REQ-018 On line_start with cen=1: bank SHALL toggle, wptr SHALL clear to 0, rptr SHALL clear to 0, rd_count SHALL load the final write count of the bank just closed, and ovf SHALL clear.
REQ-019 A write (wr_en=1, cen=1, wptr<2^AW) SHALL store wr_data at wptr and increment wptr, which is AW+1 bits wide.
REQ-020 A write with wptr=2^AW SHALL be dropped without altering storage, and SHALL set ovf.
REQ-021 If line_start and wr_en coincide, line_start SHALL take priority and the write SHALL land at entry 0 of the new write bank, leaving wptr=1.
REQ-022 A read (rd_en=1, cen=1, rptr<rd_count) SHALL present the entry at rptr on rd_data with rd_valid=1 on the next cen cycle, then increment rptr.
REQ-023 For latency, rd_data/rd_valid SHALL register one cen-qualified cycle after the request.
REQ-024 rd_last SHALL equal rd_valid AND (the presented entry index = rd_count-1).
REQ-025 With rptr=rd_count, rd_en SHALL produce rd_valid=0 with rd_data held; rptr SHALL NOT wrap.
REQ-026 A read request coinciding with line_start SHALL be discarded, and rd_valid SHALL be 0 in the following cen cycle.
REQ-027 wr_full SHALL be combinational from wptr=2^AW.

Reset
REQ-028 While rst_n=0: bank=0, wptr=0, rptr=0, rd_count=0, ovf=0, rd_valid=0, rd_last=0, and rd_data SHALL be all zeros.
REQ-029 Bank contents SHALL NOT be cleared by reset; after reset, no entry is readable until the first line_start.
REQ-030 Reset asserted mid-line SHALL abort all in-flight reads and writes immediately.

Configuration
REQ-031 Macro JTPOPEYE_OBJLINE_CLR_EN defined: each entry read SHALL be overwritten with zero in the read bank on the cycle after it is presented, so that a bank holds zeros once it has been read out.
REQ-032 Macro JTPOPEYE_OBJLINE_CLR_EN undefined: read entries SHALL keep their contents until rewritten; all other behaviour SHALL be identical.

Verification
REQ-033 Reset; write 0x00001..0x00005 into bank 0; line_start; read 5 times -> rd_data sequence 0x00001..0x00005, rd_count=5, rd_last on 5th, bank=1.
REQ-034 Write 65 entries (AW=6) within one line -> wr_full high after 64th, ovf=1 after 65th; next line reads 64 entries and rd_count=64.
REQ-035 line_start with wr_en=1 and wr_data=0x3FFFF -> new bank entry 0 = 0x3FFFF, wptr=1, and the entry is readable after the next line_start.
REQ-036 Line with 3 entries; issue 5 reads -> 3 rd_valid pulses then rd_valid=0, rd_data holds the third entry.
REQ-037 With cen=0 held for 10 cycles during wr_en/rd_en -> no pointer, bank, or output change.
REQ-038 JTPOPEYE_OBJLINE_CLR_EN defined: read 4 entries, then swap banks twice with no writes and read -> rd_count=0; a backdoor check of the bank shows zeros. Undefined: the backdoor check shows the original data.
